// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_tx_arbiter                                               |
// | Purpose  : Shares one UartTx byte transmitter among NREQ requesters.     |
// |            Round-robin arbitration happens only at packet boundaries,    |
// |            so packets never interleave on the serial line. A grant is    |
// |            also released after HOLD_MAX bytes or IDLE_TO idle cycles.    |
// | Ports    : clk, rst        clock, async active-high reset                |
// |            req_valid/data/last/ready  per-requester byte stream         |
// |            tx_we, tx_data  registered write strobe/byte to UartTx        |
// |            tx_ready        UartTx ready                                  |
// |            grant_vld, grant_id  current grant                            |
// |            forced          pulse when a grant is released without LAST   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module uart_tx_arbiter #(
  parameter int NREQ     = 4,
  parameter int HOLD_MAX = 64,
  parameter int IDLE_TO  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_we,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              grant_vld,
  output logic [2:0]        grant_id,
  output logic              forced
);

  localparam int c_id_w   = $clog2(NREQ);
  localparam int c_bcnt_w = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam int c_icnt_w = (IDLE_TO > 0) ? $clog2(IDLE_TO + 1) : 1;

  localparam logic [c_id_w-1:0]   c_last_id   = c_id_w'(NREQ - 1);
  localparam logic [c_bcnt_w-1:0] c_hold_max  = c_bcnt_w'(HOLD_MAX);
  localparam logic [c_icnt_w-1:0] c_idle_last = c_icnt_w'((IDLE_TO > 0) ? IDLE_TO - 1 : 0);

  typedef enum logic [1:0] {
    ST_ARB       = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [c_id_w-1:0]   ptr_q, ptr_d;
  logic [c_id_w-1:0]   gid_q, gid_d;
  logic                gvld_q, gvld_d;
  logic                tx_we_q, tx_we_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                forced_q, forced_d;
  logic                last_q, last_d;
  logic [c_bcnt_w-1:0] bcnt_q, bcnt_d;
  logic [c_icnt_w-1:0] icnt_q, icnt_d;

  // Round-robin scan: first valid requester starting at ptr_q.
  logic [c_id_w:0]   scan_sum;
  logic [c_id_w-1:0] scan_idx;
  logic [c_id_w-1:0] pick_id;
  logic              scan_found;

  always_comb begin
    scan_found = 1'b0;
    pick_id    = ptr_q;
    scan_sum   = '0;
    scan_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan_sum = {1'b0, ptr_q} + (c_id_w + 1)'(i);
      if (scan_sum >= (c_id_w + 1)'(NREQ)) begin
        scan_sum = scan_sum - (c_id_w + 1)'(NREQ);
      end
      scan_idx = scan_sum[c_id_w-1:0];
      if (!scan_found && req_valid[scan_idx]) begin
        scan_found = 1'b1;
        pick_id    = scan_idx;
      end
    end
  end

  // Byte stream of the granted requester.
  logic       sel_valid;
  logic       sel_last;
  logic [7:0] sel_data;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gid_q == c_id_w'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[8*i +: 8];
      end
    end
  end

  logic              accept;
  logic              hold_hit;
  logic [c_id_w-1:0] gid_next;

  assign accept   = (state_q == ST_SEND) && tx_ready && sel_valid && !rst;
  assign hold_hit = (HOLD_MAX != 0) && (bcnt_q == c_hold_max);
  // The releasing requester becomes lowest priority for the next scan.
  assign gid_next = (gid_q == c_last_id) ? '0 : gid_q + c_id_w'(1);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gid_d     = gid_q;
    gvld_d    = gvld_q;
    tx_we_d   = 1'b0;
    tx_data_d = tx_data_q;
    forced_d  = 1'b0;
    last_d    = last_q;
    bcnt_d    = bcnt_q;
    icnt_d    = icnt_q;
    req_ready = '0;

    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = accept && (gid_q == c_id_w'(i));
    end

    case (state_q)
      ST_ARB: begin
        gvld_d = 1'b0;
        if (scan_found) begin
          gid_d   = pick_id;
          gvld_d  = 1'b1;
          bcnt_d  = '0;
          icnt_d  = '0;
          last_d  = 1'b0;
          state_d = ST_SEND;
        end
      end

      ST_SEND: begin
        if (accept) begin
          tx_data_d = sel_data;
          tx_we_d   = 1'b1;
          last_d    = sel_last;
          bcnt_d    = (bcnt_q == '1) ? bcnt_q : bcnt_q + c_bcnt_w'(1);
          icnt_d    = '0;
          state_d   = ST_WAIT_ACK;
        end else if (!sel_valid && (IDLE_TO != 0)) begin
          // Idle only counts cycles where the granted requester has no byte.
          if (icnt_q == c_idle_last) begin
            ptr_d    = gid_next;
            gvld_d   = 1'b0;
            forced_d = 1'b1;
            state_d  = ST_ARB;
          end else begin
            icnt_d = icnt_q + c_icnt_w'(1);
          end
        end
      end

      ST_WAIT_ACK: begin
        // UartTx drops READY the cycle after WE; wait for that to be sure
        // the byte was taken before looking for READY to return.
        if (!tx_ready) begin
          state_d = ST_WAIT_DONE;
        end
      end

      ST_WAIT_DONE: begin
        if (tx_ready) begin
          if (last_q || hold_hit) begin
            ptr_d    = gid_next;
            gvld_d   = 1'b0;
            forced_d = !last_q;
            state_d  = ST_ARB;
          end else begin
            state_d = ST_SEND;
          end
        end
      end

      default: begin
        state_d = ST_ARB;
        gvld_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_ARB;
      ptr_q     <= '0;
      gid_q     <= '0;
      gvld_q    <= 1'b0;
      tx_we_q   <= 1'b0;
      tx_data_q <= '0;
      forced_q  <= 1'b0;
      last_q    <= 1'b0;
      bcnt_q    <= '0;
      icnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gid_q     <= gid_d;
      gvld_q    <= gvld_d;
      tx_we_q   <= tx_we_d;
      tx_data_q <= tx_data_d;
      forced_q  <= forced_d;
      last_q    <= last_d;
      bcnt_q    <= bcnt_d;
      icnt_q    <= icnt_d;
    end
  end

  assign tx_we     = tx_we_q;
  assign tx_data   = tx_data_q;
  assign grant_vld = gvld_q;
  assign grant_id  = 3'(gid_q);
  assign forced    = forced_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_tx_arbiter                                            |
// | Purpose  : Directed self-checking bench for uart_tx_arbiter. The DUT is  |
// |            built with HOLD_MAX=3 and IDLE_TO=10 so one instance covers   |
// |            normal packets, the hold limit (LAST on the limit byte is not |
// |            forced) and the idle timeout. A small UartTx model holds      |
// |            READY low for FRAME cycles after each WE.                     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_uart_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int FRAME = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              tx_we;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic              grant_vld;
  logic [2:0]        grant_id;
  logic              forced;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .HOLD_MAX(3), .IDLE_TO(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_last (req_last),
    .req_ready(req_ready),
    .tx_we    (tx_we),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .grant_vld(grant_vld),
    .grant_id (grant_id),
    .forced   (forced)
  );

  // Requester byte queues.
  logic [7:0]      qd [NREQ][32];
  logic            ql [NREQ][32];
  int              qh [NREQ];
  int              qt [NREQ];
  logic [NREQ-1:0] acc = '0;

  // UartTx model and logs.
  int   busy = 0;
  logic hold_low = 1'b0;
  int   cyc = 0;
  logic [7:0] tx_d [64];
  logic [2:0] tx_g [64];
  int         tx_c [64];
  int         tx_n = 0;
  int         f_c  [16];
  logic       f_gv [16];
  int         f_n = 0;

  int total  = 0;
  int passed = 0;

  assign tx_ready = (busy == 0) && !hold_low;

  always_comb begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (qh[i] < qt[i]) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = qd[i][qh[i]];
        req_last[i]        = ql[i][qh[i]];
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_we) begin
      busy = FRAME;
      if (tx_n < 64) begin
        tx_d[tx_n] = tx_data;
        tx_g[tx_n] = grant_id;
        tx_c[tx_n] = cyc;
      end
      tx_n++;
    end else if (busy > 0) begin
      busy--;
    end
    if (forced) begin
      if (f_n < 16) begin
        f_c[f_n]  = cyc;
        f_gv[f_n] = grant_vld;
      end
      f_n++;
    end
  end

  // Sample acceptance after the model has settled, pop just after the edge.
  always @(negedge clk) begin
    #2;
    acc = req_ready;
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) qh[i]++;
    end
  end

  task automatic push(input int r, input logic [7:0] d, input logic l);
    qd[r][qt[r]] = d;
    ql[r][qt[r]] = l;
    qt[r]++;
  endtask

  function automatic bit all_empty();
    bit e = 1'b1;
    for (int i = 0; i < NREQ; i++) if (qh[i] < qt[i]) e = 1'b0;
    return e;
  endfunction

  task automatic drain(input string name, input int budget);
    bit done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      if (all_empty() && !grant_vld && tx_ready) done = 1'b1;
    end
    total++;
    if (!done) $display("FAIL %s_drain: got timeout after %0d cycles, expected idle", name, budget);
    else passed++;
    repeat (3) @(negedge clk);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    hold_low = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      qh[i] = 0;
      qt[i] = 0;
    end
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    tx_n = 0;
    f_n  = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    push(0, 8'h5A, 1'b1);
    #1;
    total++; if (grant_vld !== 1'b0) $display("FAIL rst_gvld: got %b, expected 0", grant_vld); else passed++;
    total++; if (grant_id !== 3'd0) $display("FAIL rst_gid: got %0d, expected 0", grant_id); else passed++;
    total++; if (tx_we !== 1'b0) $display("FAIL rst_we: got %b, expected 0", tx_we); else passed++;
    total++; if (tx_data !== 8'h00) $display("FAIL rst_data: got %h, expected 00", tx_data); else passed++;
    total++; if (forced !== 1'b0) $display("FAIL rst_forced: got %b, expected 0", forced); else passed++;
    total++; if (req_ready !== 4'b0000) $display("FAIL rst_ready: got %b, expected 0000", req_ready); else passed++;
    @(negedge clk);
    total++; if (grant_vld !== 1'b0) $display("FAIL rst_hold_gvld: got %b, expected 0", grant_vld); else passed++;
    rst = 1'b0;
    drain("rst", 200);
    total++;
    if (tx_n !== 1 || tx_d[0] !== 8'h5A || tx_g[0] !== 3'd0)
      $display("FAIL rst_first_byte: got n=%0d %h/id%0d, expected n=1 5a/id0", tx_n, tx_d[0], tx_g[0]);
    else passed++;
  endtask

  task automatic test_single_packet();
    int t0;
    reset_dut();
    @(posedge clk); #1;
    t0 = cyc;
    push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b0); push(0, 8'hA3, 1'b1);
    @(negedge clk);
    total++; if (grant_vld !== 1'b0) $display("FAIL t1_pre_grant: got %b, expected 0", grant_vld); else passed++;
    @(negedge clk);
    total++;
    if (grant_vld !== 1'b1 || grant_id !== 3'd0 || req_ready !== 4'b0001)
      $display("FAIL t1_grant: got vld=%b id=%0d rdy=%b, expected vld=1 id=0 rdy=0001", grant_vld, grant_id, req_ready);
    else passed++;
    @(negedge clk);
    total++;
    if (tx_we !== 1'b1 || tx_data !== 8'hA1)
      $display("FAIL t1_first_we: got we=%b data=%h, expected we=1 data=a1", tx_we, tx_data);
    else passed++;
    drain("t1", 300);
    total++;
    if (tx_n !== 3 || tx_d[0] !== 8'hA1 || tx_d[1] !== 8'hA2 || tx_d[2] !== 8'hA3)
      $display("FAIL t1_bytes: got n=%0d %h %h %h, expected 3 a1 a2 a3", tx_n, tx_d[0], tx_d[1], tx_d[2]);
    else passed++;
    total++;
    if (tx_g[0] !== 3'd0 || tx_g[1] !== 3'd0 || tx_g[2] !== 3'd0)
      $display("FAIL t1_ids: got %0d %0d %0d, expected 0 0 0", tx_g[0], tx_g[1], tx_g[2]);
    else passed++;
    total++; if (tx_c[0] - t0 !== 2) $display("FAIL t1_latency: got %0d, expected 2", tx_c[0] - t0); else passed++;
    total++;
    if (tx_c[1] - tx_c[0] !== FRAME + 2 || tx_c[2] - tx_c[1] !== FRAME + 2)
      $display("FAIL t1_spacing: got %0d %0d, expected %0d", tx_c[1] - tx_c[0], tx_c[2] - tx_c[1], FRAME + 2);
    else passed++;
    total++; if (f_n !== 0) $display("FAIL t1_forced: got %0d pulses, expected 0", f_n); else passed++;
  endtask

  task automatic test_round_robin();
    logic [7:0] ed [7];
    logic [2:0] eg [7];
    ed = '{8'hB0, 8'hB1, 8'hC0, 8'hC1, 8'hD0, 8'hF0, 8'hE0};
    eg = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd0, 3'd2, 3'd0};
    reset_dut();
    @(posedge clk); #1;
    push(0, 8'hB0, 1'b0); push(0, 8'hB1, 1'b1);
    push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b1);
    drain("t2a", 300);
    @(posedge clk); #1;
    push(0, 8'hD0, 1'b1);
    drain("t2b", 300);
    @(posedge clk); #1;
    push(0, 8'hE0, 1'b1); push(2, 8'hF0, 1'b1);
    drain("t2c", 300);
    total++; if (tx_n !== 7) $display("FAIL t2_count: got %0d, expected 7", tx_n); else passed++;
    for (int i = 0; i < 7; i++) begin
      total++;
      if (tx_d[i] !== ed[i] || tx_g[i] !== eg[i])
        $display("FAIL t2_seq[%0d]: got %h/id%0d, expected %h/id%0d", i, tx_d[i], tx_g[i], ed[i], eg[i]);
      else passed++;
    end
    total++; if (f_n !== 0) $display("FAIL t2_forced: got %0d pulses, expected 0", f_n); else passed++;
  endtask

  task automatic test_hold_max();
    logic [7:0] ed [7];
    logic [2:0] eg [7];
    ed = '{8'h10, 8'h11, 8'h12, 8'h30, 8'h31, 8'h13, 8'h14};
    eg = '{3'd1, 3'd1, 3'd1, 3'd3, 3'd3, 3'd1, 3'd1};
    reset_dut();
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) push(1, 8'h10 + 8'(i), 1'b0);
    push(3, 8'h30, 1'b0); push(3, 8'h31, 1'b1);
    drain("t3", 400);
    total++; if (tx_n !== 7) $display("FAIL t3_count: got %0d, expected 7", tx_n); else passed++;
    for (int i = 0; i < 7; i++) begin
      total++;
      if (tx_d[i] !== ed[i] || tx_g[i] !== eg[i])
        $display("FAIL t3_seq[%0d]: got %h/id%0d, expected %h/id%0d", i, tx_d[i], tx_g[i], ed[i], eg[i]);
      else passed++;
    end
    total++; if (f_n !== 2) $display("FAIL t3_forced_count: got %0d, expected 2", f_n); else passed++;
    total++;
    if (f_c[0] - tx_c[2] !== FRAME + 1 || f_gv[0] !== 1'b0)
      $display("FAIL t3_forced_time: got dt=%0d gvld=%b, expected dt=%0d gvld=0", f_c[0] - tx_c[2], f_gv[0], FRAME + 1);
    else passed++;
  endtask

  task automatic test_idle_timeout();
    reset_dut();
    @(posedge clk); #1;
    push(0, 8'h44, 1'b0);
    drain("t4", 300);
    total++; if (tx_n !== 1 || tx_d[0] !== 8'h44) $display("FAIL t4_byte: got n=%0d %h, expected 1 44", tx_n, tx_d[0]); else passed++;
    total++; if (f_n !== 1) $display("FAIL t4_forced_count: got %0d, expected 1", f_n); else passed++;
    // FRAME+1 cycles back to SEND, then ten idle SEND cycles.
    total++;
    if (f_c[0] - tx_c[0] !== FRAME + 1 + 10)
      $display("FAIL t4_timeout: got %0d, expected %0d", f_c[0] - tx_c[0], FRAME + 11);
    else passed++;
    total++; if (f_gv[0] !== 1'b0) $display("FAIL t4_gvld: got %b, expected 0", f_gv[0]); else passed++;
  endtask

  task automatic test_stall();
    int bad = 0;
    reset_dut();
    @(posedge clk); #1;
    hold_low = 1'b1;
    push(2, 8'h99, 1'b1);
    repeat (2) @(negedge clk);
    total++;
    if (grant_vld !== 1'b1 || grant_id !== 3'd2)
      $display("FAIL t5_grant: got vld=%b id=%0d, expected vld=1 id=2", grant_vld, grant_id);
    else passed++;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready !== 4'b0000 || tx_we !== 1'b0 || grant_vld !== 1'b1) bad++;
    end
    total++; if (bad !== 0) $display("FAIL t5_stall: got %0d bad cycles, expected 0", bad); else passed++;
    @(posedge clk); #1;
    hold_low = 1'b0;
    drain("t5", 200);
    total++;
    if (tx_n !== 1 || tx_d[0] !== 8'h99 || tx_g[0] !== 3'd2 || f_n !== 0)
      $display("FAIL t5_after: got n=%0d %h/id%0d f=%0d, expected 1 99/id2 f=0", tx_n, tx_d[0], tx_g[0], f_n);
    else passed++;
  endtask

  task automatic test_reset_mid_packet();
    bit seen = 1'b0;
    reset_dut();
    @(posedge clk); #1;
    push(1, 8'h61, 1'b0); push(1, 8'h62, 1'b1);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (tx_we) seen = 1'b1;
    end
    total++; if (!seen) $display("FAIL t6_first_we: got timeout, expected tx_we"); else passed++;
    @(negedge clk);
    total++; if (grant_vld !== 1'b1) $display("FAIL t6_pre_rst: got gvld=%b, expected 1", grant_vld); else passed++;
    rst = 1'b1;
    push(0, 8'h70, 1'b1);
    #1;
    total++;
    if (grant_vld !== 1'b0 || tx_we !== 1'b0 || req_ready !== 4'b0000 || grant_id !== 3'd0)
      $display("FAIL t6_rst: got vld=%b we=%b rdy=%b id=%0d, expected 0 0 0000 0", grant_vld, tx_we, req_ready, grant_id);
    else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drain("t6", 300);
    total++;
    if (tx_n !== 3 || tx_d[1] !== 8'h70 || tx_g[1] !== 3'd0 || tx_d[2] !== 8'h62 || tx_g[2] !== 3'd1)
      $display("FAIL t6_order: got n=%0d %h/id%0d %h/id%0d, expected 3 70/id0 62/id1", tx_n, tx_d[1], tx_g[1], tx_d[2], tx_g[2]);
    else passed++;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      qh[i] = 0;
      qt[i] = 0;
    end
    test_reset();
    test_single_packet();
    test_round_robin();
    test_hold_max();
    test_idle_timeout();
    test_stall();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
